// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
package serial_add_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // The external full adder registers its outputs, so sum/carry trail a/b/c by this many cycles.
  localparam int ADD_LATENCY = 1;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_add_shreg.sv
// Right-shifting register with synchronous clear, parallel load and serial-in at the MSB.
module serial_add_shreg
  import serial_add_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic         shift,
  input  logic         sin,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d, shifted;

  generate
    if (W == 1) begin : g_one
      assign shifted = sin;
    end else begin : g_multi
      assign shifted = {sin, q_q[W-1:1]};
    end
  endgenerate

  always_comb begin
    q_d = q_q;
    if (clr)        q_d = '0;
    else if (load)  q_d = din;
    else if (shift) q_d = shifted;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial add sequencer around a 1-bit registered full adder.
// Define SERIAL_ADD_OVF_EN to add the res_ovf signed-overflow output.
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             add_a,
  output logic             add_b,
  output logic             add_c,
  input  logic             add_sum,
  input  logic             add_carry,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic             res_ovf,
`endif
  output logic             busy
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);
  localparam logic [CW-1:0] LAT  = CW'(ADD_LATENCY);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cin_q, cin_d;
  logic          cout_q, cout_d;

  logic             accept, drive, capture, finish;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic             unused_bits;

  assign accept  = (state_q == IDLE) && in_valid;
  assign drive   = (state_q == RUN) && (cnt_q != LAST);
  assign capture = (state_q == RUN) && (cnt_q >= LAT);
  assign finish  = (state_q == RUN) && (cnt_q == LAST);

  serial_add_shreg #(.W(WIDTH)) u_a (
    .clk(clk), .reset(reset), .clr(1'b0), .load(accept), .shift(drive),
    .sin(1'b0), .din(op_a), .q(a_sh)
  );

  serial_add_shreg #(.W(WIDTH)) u_b (
    .clk(clk), .reset(reset), .clr(1'b0), .load(accept), .shift(drive),
    .sin(1'b0), .din(op_b), .q(b_sh)
  );

  // Sum bits arrive at the MSB and walk down, so bit k lands at position k after WIDTH shifts.
  serial_add_shreg #(.W(WIDTH)) u_r (
    .clk(clk), .reset(reset), .clr(accept), .load(1'b0), .shift(capture),
    .sin(add_sum), .din('0), .q(r_sh)
  );

  assign unused_bits = ^{a_sh, b_sh};

  assign add_a = drive & a_sh[0];
  assign add_b = drive & b_sh[0];
  assign add_c = drive & ((cnt_q == '0) ? cin_q : add_carry);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cin_d   = cin_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = RUN;
        cnt_d   = '0;
        cin_d   = cin;
        cout_d  = 1'b0;
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (finish) begin
          state_d = DONE;
          cnt_d   = '0;
          cout_d  = add_carry;
        end
      end
      DONE: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cin_q   <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cin_q   <= cin_d;
      cout_q  <= cout_d;
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  localparam logic [CW-1:0] MSB = CW'(WIDTH - 1);
  logic cmsb_q, cmsb_d, ovf_q, ovf_d;

  always_comb begin
    cmsb_d = cmsb_q;
    ovf_d  = ovf_q;
    if (accept) ovf_d = 1'b0;
    if ((state_q == RUN) && (cnt_q == MSB)) cmsb_d = add_c;
    if (finish) ovf_d = cmsb_q ^ add_carry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmsb_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cmsb_q <= cmsb_d;
      ovf_q  <= ovf_d;
    end
  end

  assign res_ovf = ovf_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign res_sum   = r_sh;
  assign res_cout  = cout_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq (WIDTH=8 and WIDTH=1) with a registered full-adder model.
module tb_serial_add_seq;

  localparam int W = 8;

  typedef struct packed {
    logic         ovf;
    logic         cout;
    logic [W-1:0] sum;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic         in_valid = 1'b0, in_ready, cin = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0, res_sum;
  logic         add_a, add_b, add_c, add_sum, add_carry;
  logic         res_valid, res_ready = 1'b1, res_cout, busy;
  logic         res_ovf;

  serial_add_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin),
    .add_a(add_a), .add_b(add_b), .add_c(add_c),
    .add_sum(add_sum), .add_carry(add_carry),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_cout(res_cout),
`ifdef SERIAL_ADD_OVF_EN
    .res_ovf(res_ovf),
`endif
    .busy(busy)
  );

  // WIDTH=1 instance
  logic v1_in_valid = 1'b0, v1_in_ready, v1_cin = 1'b0;
  logic v1_op_a = 1'b0, v1_op_b = 1'b0, v1_res_sum;
  logic v1_add_a, v1_add_b, v1_add_c, v1_add_sum, v1_add_carry;
  logic v1_res_valid, v1_res_cout, v1_busy, v1_res_ovf;

  serial_add_seq #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(rst_n), .in_valid(v1_in_valid), .in_ready(v1_in_ready),
    .op_a(v1_op_a), .op_b(v1_op_b), .cin(v1_cin),
    .add_a(v1_add_a), .add_b(v1_add_b), .add_c(v1_add_c),
    .add_sum(v1_add_sum), .add_carry(v1_add_carry),
    .res_valid(v1_res_valid), .res_ready(1'b1),
    .res_sum(v1_res_sum), .res_cout(v1_res_cout),
`ifdef SERIAL_ADD_OVF_EN
    .res_ovf(v1_res_ovf),
`endif
    .busy(v1_busy)
  );

`ifndef SERIAL_ADD_OVF_EN
  assign res_ovf    = 1'b0;
  assign v1_res_ovf = 1'b0;
`endif

  // Registered 1-bit full adders
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_sum <= 1'b0; add_carry <= 1'b0;
      v1_add_sum <= 1'b0; v1_add_carry <= 1'b0;
    end else begin
      add_sum      <= add_a ^ add_b ^ add_c;
      add_carry    <= (add_a & add_b) | (add_a & add_c) | (add_b & add_c);
      v1_add_sum   <= v1_add_a ^ v1_add_b ^ v1_add_c;
      v1_add_carry <= (v1_add_a & v1_add_b) | (v1_add_a & v1_add_c) | (v1_add_b & v1_add_c);
    end
  end

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    logic [W:0] s;
    exp_t e;
    s      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    e.sum  = s[W-1:0];
    e.cout = s[W];
    e.ovf  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the first RUN cycle with inputs scrambled.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    in_valid = 1'b1; op_a = a; op_b = b; cin = ci;
    @(negedge clk);
    check("in_ready_before_accept", in_ready, 1'b1);
    @(posedge clk);
    sb.push_back(model(a, b, ci));
    #1;
    in_valid = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom);
  endtask

  // Returns at the negedge of the first cycle with res_valid high.
  task automatic wait_res(input string tag);
    int lat = 1, bad = 0;
    @(negedge clk);
    while (!res_valid && lat < W + 8) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) bad++;
      @(negedge clk);
      lat++;
    end
    if (busy !== 1'b1 || in_ready !== 1'b0) bad++;
    check({tag, "_latency"}, 64'(lat), 64'(W + 2));
    check({tag, "_busy_in_flight"}, 64'(bad), 64'd0);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({tag, "_sum"}, 64'(res_sum), 64'(e.sum));
    check({tag, "_cout"}, 64'(res_cout), 64'(e.cout));
`ifdef SERIAL_ADD_OVF_EN
    check({tag, "_ovf"}, 64'(res_ovf), 64'(e.ovf));
`endif
  endtask

  initial begin
    logic [W-1:0] snap_sum;
    logic         snap_cout;
    int           bad, lat;

    // Reset state
    #2;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_res", 64'({res_cout, res_sum}), 64'd0);
    check("rst_adder_in", 64'({add_a, add_b, add_c}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    send(8'h5A, 8'h3C, 1'b0); wait_res("a5a_3c"); pop_check("a5a_3c"); @(posedge clk); #1;
    send(8'hFF, 8'h01, 1'b0); wait_res("ff_01");  pop_check("ff_01");  @(posedge clk); #1;
    send(8'h7F, 8'h01, 1'b0); wait_res("7f_01");  pop_check("7f_01");  @(posedge clk); #1;
    send(8'h00, 8'h00, 1'b1); wait_res("00_00c"); pop_check("00_00c"); @(posedge clk); #1;

    // Backpressure in DONE with a competing request held valid
    res_ready = 1'b0;
    send(8'hA5, 8'h5B, 1'b1);
    wait_res("bp");
    snap_sum = res_sum; snap_cout = res_cout; bad = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; op_a = 8'h40; op_b = 8'h05; cin = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || in_ready !== 1'b0 || res_sum !== snap_sum || res_cout !== snap_cout) bad++;
      @(posedge clk); #1;
    end
    check("bp_hold_stable", 64'(bad), 64'd0);
    res_ready = 1'b1;
    @(negedge clk);
    pop_check("bp");
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_idle_after_hs", in_ready, 1'b1);
    check("bp_no_valid_after_hs", res_valid, 1'b0);
    @(posedge clk);
    sb.push_back(model(8'h40, 8'h05, 1'b1));
    #1 in_valid = 1'b0;
    wait_res("bp2"); pop_check("bp2"); @(posedge clk); #1;

    // Async reset mid-RUN (cnt=4), then a clean operation
    in_valid = 1'b1; op_a = 8'hEE; op_b = 8'hDD; cin = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_valid_busy", 64'({res_valid, busy}), 64'd0);
    check("arst_res", 64'({res_ovf, res_cout, res_sum}), 64'd0);
    check("arst_adder_in", 64'({add_a, add_b, add_c}), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'h12, 8'h34, 1'b0); wait_res("post_rst"); pop_check("post_rst"); @(posedge clk); #1;

    // WIDTH=1 instance: 1+1+1
    v1_in_valid = 1'b1; v1_op_a = 1'b1; v1_op_b = 1'b1; v1_cin = 1'b1;
    @(negedge clk);
    check("w1_in_ready", v1_in_ready, 1'b1);
    @(posedge clk); #1;
    v1_in_valid = 1'b0; v1_op_a = 1'b0; v1_op_b = 1'b0; v1_cin = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!v1_res_valid && lat < 10) begin @(negedge clk); lat++; end
    check("w1_latency", 64'(lat), 64'd3);
    check("w1_sum", v1_res_sum, 1'b1);
    check("w1_cout", v1_res_cout, 1'b1);
`ifdef SERIAL_ADD_OVF_EN
    check("w1_ovf", v1_res_ovf, 1'b0);
`endif
    @(posedge clk); #1;
    @(negedge clk);
    check("w1_idle", v1_in_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
